alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
Controller that shares one combinational alu instance among NUM_REQ requesters.
- Accepts operations through per-requester valid/ready handshakes and picks a winner round-robin.
- Registers the winning operands, drives the alu, registers the result and returns it through a per-requester response handshake.
- Sits between the processing units and the single shared alu. It also guards the alu against divide-by-zero.

Parameters:
DATA_WIDTH, 16, operand and result width; must match the alu instance.
NUM_REQ, 4, number of requesters; legal range 2..8.
OC_WIDTH, 3, opcode width; fixed at 3, not overridable in practice.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
req_valid  input  NUM_REQ  per-requester operation request.
req_ready  output  NUM_REQ  one-hot; the request is accepted when req_valid[i] and req_ready[i] are both high.
req_oc  input  3*NUM_REQ  packed opcodes; requester i uses bits [3i+2:3i].
req_a  input  DATA_WIDTH*NUM_REQ  packed operand a.
req_b  input  DATA_WIDTH*NUM_REQ  packed operand b.
alu_oc  output  3  opcode driven to the shared alu.
alu_a  output  DATA_WIDTH  operand a driven to the shared alu.
alu_b  output  DATA_WIDTH  operand b driven to the shared alu.
alu_f  input  DATA_WIDTH  combinational result from the shared alu.
rsp_valid  output  NUM_REQ  one-hot response valid for the granted requester.
rsp_ready  input  NUM_REQ  per-requester response accept.
rsp_data  output  DATA_WIDTH  registered result, shared by all requesters.
rsp_dbz  output  1  qualifies rsp_data: divide-by-zero was detected.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0, grant=0.
  - alu_oc, alu_a, alu_b = 0.
  - rsp_data=0, rsp_dbz=0.
  - rsp_valid=0, req_ready=0, busy=0.
  - Reset mid-operation discards the in-flight operation; no response is produced.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ.
  - req_ready is combinational: one-hot on the winner in IDLE only, zero in every other state.
  - On the edge where a winner exists: latch req_oc/req_a/req_b[winner] into alu_oc/alu_a/alu_b, set grant=winner, go to EXEC.
  - No valid: stay in IDLE.
- EXEC (exactly 1 cycle):
  - The alu sees stable registered inputs.
  - At the edge: rsp_data <= alu_f, rsp_dbz <= 0, then go to RESP.
  - Exception: if alu_oc==3'b011 and alu_b==0, rsp_data <= all ones and rsp_dbz <= 1; alu_f is ignored.
- RESP:
  - rsp_valid[grant]=1 (combinational from state/grant); rsp_data and rsp_dbz are held stable.
  - On rsp_ready[grant]=1: go to IDLE and set rr_ptr <= (grant+1) mod NUM_REQ.
  - rsp_ready on other indices is ignored.
  - Backpressure may last indefinitely; the state remains RESP.
- alu_oc/alu_a/alu_b hold their values outside EXEC (no toggling while idle).
- Timing:
  - Acceptance edge at cycle N; rsp_valid high from cycle N+2.
  - Minimum spacing between accepts is 3 cycles.
- Requests arriving while busy are not accepted. A requester must hold req_valid and its operands stable until req_ready.
- req_valid dropping in IDLE before acceptance: the arbiter simply re-evaluates the next cycle.
- rr_ptr wraps from NUM_REQ-1 to 0. A lone requester is served every time regardless of rr_ptr.
- Arithmetic is the alu's: results are truncated to DATA_WIDTH and unsigned. The controller does no width extension.

Test Plan:
- Reset with req_valid=0 -> all outputs 0, state IDLE; asserting rst_n=0 during RESP clears rsp_valid immediately (async).
- Single op: req 2 sends oc=000, a=0x0012, b=0x0034 -> req_ready[2] for 1 cycle; alu_a=0x0012, alu_b=0x0034 in EXEC; rsp_valid=4'b0100 two cycles after accept with rsp_data=0x0046, rsp_dbz=0.
- Round-robin: all four valid continuously, rsp_ready tied 1 -> grant order 0,1,2,3,0; each accept exactly 3 cycles apart.
- Divide-by-zero: req 1 sends oc=011, a=0x1234, b=0 -> rsp_data=0xFFFF, rsp_dbz=1; a following oc=011, a=100, b=7 -> rsp_data=14, rsp_dbz=0.
- Backpressure: hold rsp_ready[0]=0 for 10 cycles while req 3 is valid -> rsp_valid[0] and rsp_data stay stable and req_ready stays 0; after rsp_ready[0]=1, req 3 is granted on the next cycle.
- Wrap and lone requester: rr_ptr=3 with only req 0 valid -> req 0 granted; MUL with a=0x0100, b=0x0100 -> rsp_data=0x0000 (truncated).

Source files
------------

// File: rtl/alu_share_ctrl.sv
// Round-robin controller that time-shares one combinational alu among NUM_REQ requesters.
// Operands are registered into the alu for one cycle and the result is returned through a response handshake.
module alu_share_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int OC_WIDTH   = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [OC_WIDTH*NUM_REQ-1:0]    req_oc,
  input  logic [DATA_WIDTH*NUM_REQ-1:0]  req_a,
  input  logic [DATA_WIDTH*NUM_REQ-1:0]  req_b,
  output logic [OC_WIDTH-1:0]            alu_oc,
  output logic [DATA_WIDTH-1:0]          alu_a,
  output logic [DATA_WIDTH-1:0]          alu_b,
  input  logic [DATA_WIDTH-1:0]          alu_f,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic                           rsp_dbz,
  output logic                           busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [OC_WIDTH-1:0] OC_DIV   = OC_WIDTH'(3);
  localparam logic [PTR_W-1:0]    LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [1:0]            state;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      grant;
  logic [PTR_W-1:0]      winner;
  logic                  found;
  logic                  div_by_zero;

  logic [OC_WIDTH-1:0]   oc_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] a_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] b_arr  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign oc_arr[i] = req_oc[i*OC_WIDTH +: OC_WIDTH];
    assign a_arr[i]  = req_a[i*DATA_WIDTH +: DATA_WIDTH];
    assign b_arr[i]  = req_b[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search starts at rr_ptr and wraps, so the last-served requester has lowest priority.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a missed path infers a latch.
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        found  = 1'b1;
        winner = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) req_ready[winner] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state == RESP) rsp_valid[grant] = 1'b1;
  end

  assign busy        = (state != IDLE);
  assign div_by_zero = (alu_oc == OC_DIV) && (alu_b == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      alu_oc   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      rsp_data <= '0;
      rsp_dbz  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (found) begin
            alu_oc <= oc_arr[winner];
            alu_a  <= a_arr[winner];
            alu_b  <= b_arr[winner];
            grant  <= winner;
            state  <= EXEC;
          end
        end
        EXEC: begin
          // The alu's own divide-by-zero output is not trusted; a saturated result is substituted.
          if (div_by_zero) begin
            rsp_data <= '1;
            rsp_dbz  <= 1'b1;
          end else begin
            rsp_data <= alu_f;
            rsp_dbz  <= 1'b0;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready[grant]) begin
            rr_ptr <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl with a behavioural model of the shared alu.
// Opcodes of the model: 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 xor, 111 pass a.
module tb_alu_share_ctrl;

  localparam int DW = 16;
  localparam int NR = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  logic [3*NR-1:0]  req_oc;
  logic [DW*NR-1:0] req_a;
  logic [DW*NR-1:0] req_b;
  logic [2:0]     alu_oc;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [DW-1:0]  alu_f;
  logic [NR-1:0]  rsp_valid;
  logic [NR-1:0]  rsp_ready;
  logic [DW-1:0]  rsp_data;
  logic           rsp_dbz;
  logic           busy;

  int n_cmp = 0;
  int n_err = 0;

  alu_share_ctrl #(.DATA_WIDTH(DW), .NUM_REQ(NR), .OC_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_oc(req_oc), .req_a(req_a), .req_b(req_b),
    .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_dbz(rsp_dbz), .busy(busy)
  );

  always #5 clk = ~clk;

  // Divide by zero returns a distinctive value the controller must override.
  always_comb begin
    alu_f = '0;
    case (alu_oc)
      3'b000: alu_f = alu_a + alu_b;
      3'b001: alu_f = alu_a - alu_b;
      3'b010: alu_f = alu_a * alu_b;
      3'b011: alu_f = (alu_b == '0) ? 16'h0BAD : alu_a / alu_b;
      3'b100: alu_f = alu_a & alu_b;
      3'b101: alu_f = alu_a | alu_b;
      3'b110: alu_f = alu_a ^ alu_b;
      default: alu_f = alu_a;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] oc, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
    req_oc[3*i +: 3]  = oc;
    req_a[DW*i +: DW] = a;
    req_b[DW*i +: DW] = b;
    req_valid[i]      = 1'b1;
  endtask

  logic [DW-1:0] rr_exp [NR];

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_oc = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_alu_oc", 32'(alu_oc), 32'h0);
    check("rst_alu_a", 32'(alu_a), 32'h0);
    check("rst_alu_b", 32'(alu_b), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);
    check("rst_rsp_dbz", 32'(rsp_dbz), 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("idle_no_req_busy", 32'(busy), 32'h0);

    // Single add from requester 2.
    set_req(2, 3'b000, 16'h0012, 16'h0034);
    #1;
    check("single_req_ready", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    check("single_exec_busy", 32'(busy), 32'h1);
    check("single_exec_ready", 32'(req_ready), 32'h0);
    check("single_exec_alu_oc", 32'(alu_oc), 32'h0);
    check("single_exec_alu_a", 32'(alu_a), 32'h0012);
    check("single_exec_alu_b", 32'(alu_b), 32'h0034);
    check("single_exec_rsp_valid", 32'(rsp_valid), 32'h0);
    step();
    check("single_rsp_valid", 32'(rsp_valid), 32'b0100);
    check("single_rsp_data", 32'(rsp_data), 32'h0046);
    check("single_rsp_dbz", 32'(rsp_dbz), 32'h0);
    rsp_ready = 4'b0100;
    step();
    rsp_ready = '0;
    check("single_done_busy", 32'(busy), 32'h0);
    check("single_done_rsp_valid", 32'(rsp_valid), 32'h0);

    // Divide by zero from requester 1 (rr_ptr is 3).
    set_req(1, 3'b011, 16'h1234, 16'h0000);
    #1;
    check("dbz_req_ready", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    step();
    check("dbz_rsp_valid", 32'(rsp_valid), 32'b0010);
    check("dbz_rsp_data", 32'(rsp_data), 32'hFFFF);
    check("dbz_rsp_dbz", 32'(rsp_dbz), 32'h1);
    rsp_ready = 4'b0010;
    step();
    rsp_ready = '0;
    set_req(1, 3'b011, 16'd100, 16'd7);
    #1;
    check("div_req_ready", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    step();
    check("div_rsp_data", 32'(rsp_data), 32'd14);
    check("div_rsp_dbz", 32'(rsp_dbz), 32'h0);
    rsp_ready = 4'b0010;
    step();
    rsp_ready = '0;

    // Backpressure on requester 0 while requester 3 waits (rr_ptr is 2).
    set_req(0, 3'b000, 16'd5, 16'd6);
    #1;
    check("bp_req_ready0", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    set_req(3, 3'b001, 16'd3, 16'd5);
    step();
    rsp_ready = 4'b1110;
    for (int c = 0; c < 10; c++) begin
      #1;
      check("bp_rsp_valid", 32'(rsp_valid), 32'b0001);
      check("bp_rsp_data", 32'(rsp_data), 32'd11);
      check("bp_req_ready", 32'(req_ready), 32'h0);
      check("bp_alu_a_held", 32'(alu_a), 32'd5);
      step();
    end
    rsp_ready = 4'b0001;
    step();
    rsp_ready = '0;
    check("bp_release_ready3", 32'(req_ready), 32'b1000);
    step();
    req_valid = '0;
    step();
    check("sub_rsp_valid", 32'(rsp_valid), 32'b1000);
    check("sub_rsp_data", 32'(rsp_data), 32'hFFFE);
    rsp_ready = 4'b1000;
    step();
    rsp_ready = '0;

    // Serve requester 2 so rr_ptr becomes 3, then lone requester 0 must win via wrap.
    set_req(2, 3'b100, 16'hF0F0, 16'hFF00);
    step();
    req_valid = '0;
    step();
    check("and_rsp_data", 32'(rsp_data), 32'hF000);
    rsp_ready = 4'b0100;
    step();
    rsp_ready = '0;
    set_req(0, 3'b010, 16'h0100, 16'h0100);
    #1;
    check("wrap_req_ready", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    step();
    check("mul_trunc_rsp_data", 32'(rsp_data), 32'h0000);
    check("mul_trunc_rsp_valid", 32'(rsp_valid), 32'b0001);

    // Asynchronous reset while in RESP discards the response immediately.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_rsp_data", 32'(rsp_data), 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Round-robin with all requesters valid and responses always accepted.
    rr_exp[0] = 16'h0001; rr_exp[1] = 16'h0012; rr_exp[2] = 16'h0023; rr_exp[3] = 16'h0034;
    for (int i = 0; i < NR; i++) set_req(i, 3'b000, DW'(i + 1), DW'(16 * i));
    rsp_ready = '1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("rr_grant", 32'(req_ready), 32'(1 << (k % NR)));
      step();
      check("rr_exec_ready", 32'(req_ready), 32'h0);
      step();
      check("rr_resp_ready", 32'(req_ready), 32'h0);
      check("rr_rsp_valid", 32'(rsp_valid), 32'(1 << (k % NR)));
      check("rr_rsp_data", 32'(rsp_data), 32'(rr_exp[k % NR]));
      step();
    end
    req_valid = '0;
    rsp_ready = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
